// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared event kinds, FSM states and counter-width helper for btn_event_ctrl
package btn_pkg;

    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        RELEASE = 2'd1,
        LONG    = 2'd2,
        REPEAT  = 2'd3
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_DOWN     = 2'd2,
        ST_REL_DB   = 2'd3
    } btn_state_e;

    // Bits needed to hold values 0..max, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// rtl/btn_event_fsm.sv - per-button debounce/hold FSM with one pending event slot; REPEAT under BTN_EVENT_REPEAT_EN
module btn_event_fsm
    import btn_pkg::*;
#(
    parameter int unsigned DEB_TICKS    = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_i,
    input  logic      btn_i,
    input  logic      grant_i,
    output logic      pressed_o,
    output logic      pend_o,
    output evt_kind_e kind_o,
    output logic      drop_o
);

    localparam int unsigned DW = cnt_w(DEB_TICKS);
    localparam int unsigned HW = cnt_w(LONG_TICKS);
    localparam bit          DEB_NONE = (DEB_TICKS <= 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_NONE ? 0 : DEB_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_TICKS);

    btn_state_e    state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    evt_kind_e     kind_q, kind_d;
    logic          fire, go_down, go_idle;
    evt_kind_e     fire_kind;
`ifdef BTN_EVENT_REPEAT_EN
    localparam int unsigned RW = cnt_w(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        fire      = 1'b0;
        fire_kind = PRESS;
        go_down   = 1'b0;
        go_idle   = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (tick_i) begin
            case (state_q)
                ST_IDLE: if (btn_i) begin
                    deb_d = DW'(1);
                    if (DEB_NONE) go_down = 1'b1;
                    else          state_d = ST_PRESS_DB;
                end
                ST_PRESS_DB: begin
                    if (!btn_i)                 state_d = ST_IDLE;
                    else if (deb_q == DEB_LAST) go_down = 1'b1;
                    else                        deb_d   = deb_q + 1'b1;
                end
                ST_DOWN: begin
                    if (!btn_i) begin
                        deb_d = DW'(1);
                        if (DEB_NONE) go_idle = 1'b1;
                        else          state_d = ST_REL_DB;
                    end else if (hold_q != LONG_SAT) begin
                        hold_d = hold_q + 1'b1;
                        if (hold_q == LONG_LAST) begin
                            fire      = 1'b1;
                            fire_kind = LONG;
                        end
                    end
`ifdef BTN_EVENT_REPEAT_EN
                    else begin
                        // Saturated hold count: repeat counter runs from the LONG tick.
                        rep_d = rep_q + 1'b1;
                        if (rep_q == REP_LAST) begin
                            rep_d     = '0;
                            fire      = 1'b1;
                            fire_kind = REPEAT;
                        end
                    end
`endif
                end
                ST_REL_DB: begin
                    if (btn_i)                  state_d = ST_DOWN;
                    else if (deb_q == DEB_LAST) go_idle = 1'b1;
                    else                        deb_d   = deb_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (go_down) begin
            state_d   = ST_DOWN;
            hold_d    = '0;
            fire      = 1'b1;
            fire_kind = PRESS;
`ifdef BTN_EVENT_REPEAT_EN
            rep_d     = '0;
`endif
        end
        if (go_idle) begin
            state_d   = ST_IDLE;
            fire      = 1'b1;
            fire_kind = RELEASE;
        end
    end

    // A granted slot is free this cycle, so only an ungranted one is overwritten.
    always_comb begin
        pend_d = pend_q & ~grant_i;
        kind_d = kind_q;
        drop_o = 1'b0;
        if (fire) begin
            drop_o = pend_q & ~grant_i;
            pend_d = 1'b1;
            kind_d = fire_kind;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            kind_q  <= PRESS;
`ifdef BTN_EVENT_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            kind_q  <= kind_d;
`ifdef BTN_EVENT_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign pressed_o = (state_q == ST_DOWN) || (state_q == ST_REL_DB);
    assign pend_o    = pend_q;
    assign kind_o    = kind_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - button event controller: sync, prescaler, per-button FSMs, arbiter, event FIFO; option BTN_EVENT_REPEAT_EN
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DEB_TICKS    = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [N_BTN-1:0]                           btn_n,
    output logic [N_BTN-1:0]                           pressed,
    output logic                                       evt_valid,
    input  logic                                       evt_ready,
    output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_btn,
    output logic [1:0]                                 evt_kind,
    output logic                                       overflow,
    input  logic                                       clr_overflow
);

    localparam int unsigned BW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned PW = cnt_w(TICK_DIV - 1);
    localparam int unsigned AW = cnt_w(FIFO_DEPTH - 1);
    localparam int unsigned CW = cnt_w(FIFO_DEPTH);

    // Synchronisers reset to the released level so reset never fakes a press.
    logic [N_BTN-1:0] sync1_q, sync2_q, btn_s;
    logic [PW-1:0]    div_q, div_d;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            div_q   <= div_d;
        end
    end

    assign btn_s = ~sync2_q;
    assign tick  = (div_q == PW'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    logic [N_BTN-1:0] pend, grant, fsm_drop;
    evt_kind_e        pend_kind [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_event_fsm #(
            .DEB_TICKS    (DEB_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_i    (tick),
            .btn_i     (btn_s[i]),
            .grant_i   (grant[i]),
            .pressed_o (pressed[i]),
            .pend_o    (pend[i]),
            .kind_o    (pend_kind[i]),
            .drop_o    (fsm_drop[i])
        );
    end

    logic          push, push_ok, pop, full, drop;
    logic [BW-1:0] push_btn;
    evt_kind_e     push_kind;

    // Scan high to low so the lowest pending index wins.
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_btn  = '0;
        push_kind = PRESS;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                push      = 1'b1;
                push_btn  = BW'(i);
                push_kind = pend_kind[i];
            end
        end
    end

    logic [BW-1:0] mem_btn_q  [FIFO_DEPTH];
    logic [BW-1:0] mem_btn_d  [FIFO_DEPTH];
    evt_kind_e     mem_kind_q [FIFO_DEPTH];
    evt_kind_e     mem_kind_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d, ovf_q, ovf_d;
    logic [BW-1:0] head_btn_q, head_btn_d;
    evt_kind_e     head_kind_q, head_kind_d;

    assign pop     = valid_q & evt_ready;
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);
    assign drop    = (push & ~push_ok) | (|fsm_drop);
    assign ovf_d   = drop | (ovf_q & ~clr_overflow);

    // Head registers are loaded from the post-update array so they track pushes and pops.
    always_comb begin
        mem_btn_d  = mem_btn_q;
        mem_kind_d = mem_kind_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (push_ok) begin
            mem_btn_d[wr_q]  = push_btn;
            mem_kind_d[wr_q] = push_kind;
            wr_d = (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        valid_d     = (cnt_d != '0);
        head_btn_d  = mem_btn_d[rd_d];
        head_kind_d = mem_kind_d[rd_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_btn_q[i]  <= '0;
                mem_kind_q[i] <= PRESS;
            end
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            head_btn_q  <= '0;
            head_kind_q <= PRESS;
            ovf_q       <= 1'b0;
        end else begin
            mem_btn_q   <= mem_btn_d;
            mem_kind_q  <= mem_kind_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            head_btn_q  <= head_btn_d;
            head_kind_q <= head_kind_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_btn   = head_btn_q;
    assign evt_kind  = head_kind_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl (REPEAT expectations follow BTN_EVENT_REPEAT_EN)
module tb_btn_event_ctrl;

    localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] pressed;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_btn;
    logic [1:0] evt_kind;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    btn_event_ctrl #(
        .N_BTN        (4),
        .TICK_DIV     (4),
        .DEB_TICKS    (3),
        .LONG_TICKS   (10),
        .REPEAT_TICKS (4),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .pressed      (pressed),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_kind     (evt_kind),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_btn[$];
    int q_kind[$];
    int q_cyc[$];

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            q_btn.push_back(int'(evt_btn));
            q_kind.push_back(int'(evt_kind));
            q_cyc.push_back(cyc);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_btn.delete();
        q_kind.delete();
        q_cyc.delete();
    endtask

    task automatic wait_events(input int n, input int budget);
        int k = 0;
        while (q_btn.size() < n && k < budget) begin
            step(1);
            k++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step(3);
        tests++; if (pressed !== 4'h0) begin fails++; $display("FAIL reset_pressed: got %h want 0", pressed); end
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        tests++; if (evt_btn !== 2'd0 || evt_kind !== 2'd0) begin fails++; $display("FAIL reset_head: got btn %0d kind %0d want 0 0", evt_btn, evt_kind); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst_n = 1'b1;
        step(8);
        clear_q();
    endtask

    task automatic test_press_release();
        btn_n[1] = 1'b0;
        step(20);
        tests++; if (pressed !== 4'b0010) begin fails++; $display("FAIL pr_pressed_mid: got %b want 0010", pressed); end
        btn_n[1] = 1'b1;
        step(32);
        tests++; if (pressed !== 4'b0000) begin fails++; $display("FAIL pr_pressed_end: got %b want 0000", pressed); end
        tests++; if (q_btn.size() != 2) begin fails++; $display("FAIL pr_count: got %0d events want 2", q_btn.size()); end
        tests++; if (q_btn[0] != 1 || q_kind[0] != K_PRESS) begin fails++; $display("FAIL pr_first: got btn %0d kind %0d want 1 0", q_btn[0], q_kind[0]); end
        tests++; if (q_btn[1] != 1 || q_kind[1] != K_RELEASE) begin fails++; $display("FAIL pr_second: got btn %0d kind %0d want 1 1", q_btn[1], q_kind[1]); end
        clear_q();
    endtask

    task automatic test_bounce();
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            btn_n[0] = ~btn_n[0];
            step(4);
            if (pressed !== 4'h0) seen++;
        end
        btn_n[0] = 1'b1;
        step(20);
        tests++; if (seen != 0) begin fails++; $display("FAIL bounce_pressed: got %0d samples pressed want 0", seen); end
        tests++; if (q_btn.size() != 0) begin fails++; $display("FAIL bounce_events: got %0d events want 0", q_btn.size()); end
        clear_q();
    endtask

    task automatic test_long();
        int n_exp;
        btn_n[2] = 1'b0;
        wait_events(1, 100);
        tests++; if (q_btn.size() < 1) begin fails++; $display("FAIL long_press_timeout: got %0d events want 1", q_btn.size()); end
        step(76);
        btn_n[2] = 1'b1;
        step(40);
`ifdef BTN_EVENT_REPEAT_EN
        n_exp = 5;
`else
        n_exp = 3;
`endif
        tests++; if (q_btn.size() != n_exp) begin fails++; $display("FAIL long_count: got %0d events want %0d", q_btn.size(), n_exp); end
        tests++; if (q_btn[0] != 2 || q_kind[0] != K_PRESS) begin fails++; $display("FAIL long_ev0: got btn %0d kind %0d want 2 0", q_btn[0], q_kind[0]); end
        tests++; if (q_btn[1] != 2 || q_kind[1] != K_LONG) begin fails++; $display("FAIL long_ev1: got btn %0d kind %0d want 2 2", q_btn[1], q_kind[1]); end
        tests++; if (q_cyc[1] - q_cyc[0] != 40) begin fails++; $display("FAIL long_delay: got %0d cycles want 40", q_cyc[1] - q_cyc[0]); end
`ifdef BTN_EVENT_REPEAT_EN
        tests++; if (q_kind[2] != K_REPEAT || q_kind[3] != K_REPEAT) begin fails++; $display("FAIL long_repeat_kind: got %0d %0d want 3 3", q_kind[2], q_kind[3]); end
        tests++; if (q_cyc[2] - q_cyc[1] != 16 || q_cyc[3] - q_cyc[2] != 16) begin fails++; $display("FAIL long_repeat_gap: got %0d %0d want 16 16", q_cyc[2] - q_cyc[1], q_cyc[3] - q_cyc[2]); end
`endif
        tests++; if (q_btn[n_exp-1] != 2 || q_kind[n_exp-1] != K_RELEASE) begin fails++; $display("FAIL long_release: got btn %0d kind %0d want 2 1", q_btn[n_exp-1], q_kind[n_exp-1]); end
        clear_q();
    endtask

    task automatic test_simultaneous();
        btn_n = 4'b0110;
        wait_events(2, 100);
        tests++; if (q_btn[0] != 0 || q_kind[0] != K_PRESS) begin fails++; $display("FAIL sim_first: got btn %0d kind %0d want 0 0", q_btn[0], q_kind[0]); end
        tests++; if (q_btn[1] != 3 || q_kind[1] != K_PRESS) begin fails++; $display("FAIL sim_second: got btn %0d kind %0d want 3 0", q_btn[1], q_kind[1]); end
        btn_n = 4'hF;
        wait_events(4, 100);
        tests++; if (q_btn[2] != 0 || q_btn[3] != 3 || q_kind[2] != K_RELEASE || q_kind[3] != K_RELEASE) begin
            fails++; $display("FAIL sim_release: got btn %0d/%0d kind %0d/%0d want 0/3 1/1", q_btn[2], q_btn[3], q_kind[2], q_kind[3]);
        end
        step(8);
        clear_q();
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        btn_n = 4'b1000;
        step(30);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
        tests++; if (evt_valid !== 1'b1 || evt_btn !== 2'd0 || evt_kind !== 2'd0) begin
            fails++; $display("FAIL ovf_head: got v%b btn %0d kind %0d want v1 0 0", evt_valid, evt_btn, evt_kind);
        end
        evt_ready = 1'b1;
        step(4);
        tests++; if (q_btn.size() != 2 || q_btn[0] != 0 || q_btn[1] != 1) begin
            fails++; $display("FAIL ovf_kept: got %0d events btn %0d,%0d want 2 events 0,1", q_btn.size(), q_btn[0], q_btn[1]);
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        btn_n = 4'hF;
        step(30);
        clear_q();
    endtask

    task automatic test_reset_mid();
        int rel;
        btn_n[3] = 1'b0;
        wait_events(1, 100);
        step(8);
        tests++; if (pressed !== 4'b1000) begin fails++; $display("FAIL rm_down: got %b want 1000", pressed); end
        rst_n = 1'b0;
        #1;
        tests++; if (pressed !== 4'h0 || evt_valid !== 1'b0) begin fails++; $display("FAIL rm_async: got pressed %b valid %b want 0 0", pressed, evt_valid); end
        step(3);
        clear_q();
        rst_n = 1'b1;
        rel = cyc;
        wait_events(1, 100);
        tests++; if (q_btn.size() < 1 || q_btn[0] != 3 || q_kind[0] != K_PRESS) begin
            fails++; $display("FAIL rm_first: got %0d events btn %0d kind %0d want btn 3 kind 0", q_btn.size(), q_btn[0], q_kind[0]);
        end
        tests++; if (q_cyc[0] - rel != 13) begin fails++; $display("FAIL rm_latency: got %0d cycles want 13", q_cyc[0] - rel); end
        btn_n = 4'hF;
        step(30);
        clear_q();
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_long();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of buttons (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000, clk cycles per sample tick (must be >= N_BTN+2).
REQ-003 SHALL have parameter DEB_TICKS, default 20, consecutive differing ticks to commit a level change.
REQ-004 SHALL have parameter LONG_TICKS, default 1000, ticks held before a LONG event.
REQ-005 SHALL have parameter REPEAT_TICKS, default 200, ticks between REPEAT events after LONG.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two).
REQ-007 SHALL have port clk, input, 1, the single clock for all logic.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port btn_n, input, N_BTN, raw asynchronous buttons, active low.
REQ-010 SHALL have port pressed, output, N_BTN, debounced level, 1 = held.
REQ-011 SHALL have port evt_valid, output, 1, queue head valid.
REQ-012 SHALL have port evt_ready, input, 1, consumer accepts head.
REQ-013 SHALL have port evt_btn, output, $clog2(N_BTN) (min 1), button index of head.
REQ-014 SHALL have port evt_kind, output, 2, PRESS=0, RELEASE=1, LONG=2, REPEAT=3.
REQ-015 SHALL have port overflow, output, 1, sticky: an event was dropped.
REQ-016 SHALL have port clr_overflow, input, 1, clears overflow.

Function
REQ-017 SHALL synchronise each btn_n bit through two flops and invert it before any use.
REQ-018 SHALL generate a one-cycle tick every TICK_DIV clk cycles from a shared prescaler; all debounce and hold timing counts ticks only.
REQ-019 Per-button FSM SHALL have states IDLE, PRESS_DB, DOWN, REL_DB; IDLE->PRESS_DB on a tick with the input pressed; PRESS_DB->IDLE on a tick with the input released; PRESS_DB->DOWN after DEB_TICKS consecutive pressed ticks.
REQ-020 DOWN->REL_DB on a tick with the input released; REL_DB->DOWN on a tick with the input pressed, keeping the hold count; REL_DB->IDLE after DEB_TICKS consecutive released ticks.
REQ-021 SHALL raise PRESS on entry to DOWN from PRESS_DB and RELEASE on entry to IDLE from REL_DB; pressed[i] SHALL be 1 exactly in DOWN and REL_DB.
REQ-022 SHALL count DOWN ticks from zero on PRESS, saturating; LONG is raised once when the count reaches LONG_TICKS.
REQ-023 Each FSM SHALL hold one pending event until the arbiter grants it; the arbiter SHALL grant the lowest pending index, one push per cycle.
REQ-024 A new event in an FSM that already has a pending event SHALL replace it and set overflow.
REQ-025 Push into a full FIFO SHALL drop the event and set overflow; push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-026 evt_* SHALL be registered FIFO head outputs; the head is popped when evt_valid && evt_ready; a pushed event SHALL appear at evt_valid no earlier than 1 cycle after the push.
REQ-027 clr_overflow SHALL clear overflow unless a drop occurs in the same cycle, in which case overflow stays 1.

Reset
REQ-028 rst_n low SHALL asynchronously force all FSMs to IDLE, clear all counters, the prescaler, pending flags and FIFO, and drive pressed=0, evt_valid=0, evt_btn=0, evt_kind=0, overflow=0.
REQ-029 A button held through reset release SHALL produce PRESS after DEB_TICKS ticks, never a RELEASE first.

Configuration
REQ-030 With BTN_EVENT_REPEAT_EN defined, after LONG the FSM SHALL raise REPEAT every REPEAT_TICKS ticks while in DOWN; without it, REPEAT_TICKS SHALL be unused and kind 3 SHALL never be emitted.

Structure
REQ-031 Package btn_pkg SHALL hold the evt_kind_e enum (PRESS, RELEASE, LONG, REPEAT) and the FSM state enum.
REQ-032 The per-button FSM with its counters SHALL be sub-module btn_event_fsm, generated N_BTN times; the prescaler, arbiter and FIFO SHALL remain in btn_event_ctrl.

Verification
All scenarios use TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4, FIFO_DEPTH=2, with evt_ready=1 unless stated.
REQ-033 Press btn_n[1] for 5 ticks, then release it -> PRESS(btn 1) once, then RELEASE(btn 1) once, with pressed[1] high between them.
REQ-034 Toggle btn_n[0] each tick for 20 ticks -> no events and pressed=0.
REQ-035 Hold btn 2 for 20 ticks with REPEAT enabled -> PRESS, LONG at hold tick 10, REPEAT at ticks 14 and 18; with REPEAT disabled -> PRESS and LONG only.
REQ-036 Press buttons 0 and 3 on the same tick -> PRESS(0) is queued before PRESS(3).
REQ-037 Hold evt_ready=0 and generate 3 events -> first 2 are kept in order and overflow=1; clr_overflow clears overflow.
REQ-038 Assert rst_n low mid-DOWN -> outputs reset at once; the held button yields PRESS 3 ticks after reset release.
